keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Parametrised matrix-keypad scanner that succeeds the fixed 4-row polling controller.
- Drives one row at a time and samples the column lines.
- Debounces both press and release, and encodes the key as a binary index.
- Delivers each press as one event over a valid/ack handshake with overrun detection. Sits between the keypad pins and the calculator FSM.

Parameters:
- ROWS, 4, number of driven row lines (2..8).
- COLS, 4, number of sensed column lines (2..8).
- SCAN_DIV, 4, CLK cycles each row is driven before its columns are sampled (>=2).
- DEBOUNCE, 8, consecutive stable samples required to accept a press or a release (>=1).
- REPEAT_DLY, 64, cycles held before the first auto-repeat (AUTOREPEAT_EN only).
- REPEAT_PER, 16, cycles between later auto-repeats (AUTOREPEAT_EN only).

Ports:
- CLK, in, 1, system clock.
- RESET, in, 1, synchronous active-low reset.
- EnableKeyb, in, 1, scan enable. When 0: scanning freezes in SCAN, ROW_DRV=0, no new events; a pending event is kept.
- COL_IN, in, COLS, raw column lines, active-high, asynchronous.
- ROW_DRV, out, ROWS, one-hot row drive, active-high.
- KEY_CODE, out, KW=$clog2(ROWS*COLS), code = row*COLS + col.
- KEY_VALID, out, 1, event pending.
- KEY_ACK, in, 1, consumer accepts the event.
- KEY_DOWN, out, 1, a debounced key is currently held.
- OVERRUN, out, 1, one-cycle pulse when an event is lost.

Behaviour:
- Reset (RESET==0 at a CLK edge): all outputs 0, state=SCAN, row=0, all counters 0, synchroniser cleared.
- COL_IN passes through a 2-flop synchroniser (csync). All column decisions use csync, giving 2 cycles of input latency.
- Column select: if several columns are active, the lowest index wins.
- SCAN:
  - ROW_DRV=1<<row. A slot counter counts 0..SCAN_DIV-1.
  - At the last slot cycle, sample csync. If nonzero: latch col, go to PRESS_DB with deb counter=1. Else: row wraps (row==ROWS-1 -> 0), slot counter=0.
- PRESS_DB:
  - Row held. The same col must stay active each cycle.
  - When the counter reaches DEBOUNCE: go to HELD, raise KEY_DOWN, emit the event.
  - If the col drops before that: advance to the next row and go to SCAN.
- HELD:
  - Row held, KEY_DOWN=1.
  - col inactive -> REL_DB with counter=1.
- REL_DB:
  - After DEBOUNCE consecutive inactive samples: KEY_DOWN=0, advance row, go to SCAN.
  - If col is active again: return to HELD with no new event.
- Event emission:
  - KEY_VALID==0: load KEY_CODE, KEY_VALID=1 on the next edge.
  - KEY_VALID==1 and KEY_ACK==0: KEY_CODE unchanged, OVERRUN pulses, new event discarded.
  - Same cycle as KEY_ACK: the new event loads and KEY_VALID stays 1, with no overrun.
- Handshake:
  - KEY_VALID and KEY_CODE are stable until KEY_ACK is sampled high while KEY_VALID=1. KEY_VALID clears on that edge.
  - KEY_ACK while KEY_VALID=0 is ignored.
- Latency: from stable csync at the row's sample cycle to KEY_VALID=1 is DEBOUNCE+1 cycles.
- Reset mid-operation (any state): the pending event is dropped and all outputs return to 0 on that edge.
- EnableKeyb 1->0 in PRESS_DB, HELD or REL_DB: KEY_DOWN=0 and go to SCAN at row 0. No event is generated if the press was not yet accepted.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter starts at the acceptance of the press.
  - After REPEAT_DLY cycles, and then every REPEAT_PER cycles, the same KEY_CODE is emitted through normal event emission; overrun rules apply.
  - The counter resets on leaving HELD.
- Undefined: no repeat logic or counter is synthesised; exactly one event per debounced press.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding: SCAN, PRESS_DB, HELD, REL_DB;
  - the KW width function;
  - default constants.
- One sub-module: keypad_evt_reg, the one-entry event holding register with valid/ack/overrun logic. It is reusable for other input devices.
- The scanner FSM, synchroniser and counters live in keypad_scan_ctrl.

Test Plan:
All cases use default parameters.
1. Reset: hold RESET=0 for 3 cycles, then release with EnableKeyb=1 -> all outputs 0 during reset; ROW_DRV=0001 on the first cycle after release, 0010 after 4 cycles.
2. Press row 2 col 1 (COL_IN=0010 while ROW_DRV=0100) and hold -> after 8 stable samples KEY_CODE=9, KEY_VALID=1, KEY_DOWN=1; ROW_DRV stays 0100.
3. Bounce: pulse COL_IN for 5 cycles during row 1 -> no KEY_VALID, scan resumes at row 2.
4. Multiple columns: COL_IN=1100 on row 0 -> KEY_CODE=2 (lowest column wins).
5. Release and handshake: release the key of case 2 with no ack, then press key 5 without ack -> OVERRUN pulses once and KEY_CODE remains 9. Ack on a later cycle with no new event in that cycle -> KEY_VALID=0 on the next edge.
6. Auto-repeat, with KEYPAD_AUTOREPEAT_EN defined: hold key 0 and ack every event -> events at acceptance, +64, +80 and +96 cycles. With the macro undefined -> exactly one event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: state encoding, code-width helper, defaults.
// No logic; imported by the scanner top.
// Only the scanner top depends on it; the event register does not.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } kp_state_e;

    localparam int KP_ROWS       = 4;
    localparam int KP_COLS       = 4;
    localparam int KP_SCAN_DIV   = 4;
    localparam int KP_DEBOUNCE   = 8;
    localparam int KP_REPEAT_DLY = 64;
    localparam int KP_REPEAT_PER = 16;

    // Width of a binary key index for a rows x cols matrix (at least one bit).
    function automatic int kp_kw(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_evt_reg.sv
// One-entry event holding register with valid/ack handshake and overrun pulse.
// Latency: in_vld to out_vld is one cycle; overrun is a one-cycle pulse on the edge after a drop.
// Backpressure: a new event while full and not acked is discarded; an ack in the same cycle frees the slot.
module keypad_evt_reg #(
    parameter int W = 4
) (
    input  logic         core_clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_ack,
    output logic         overrun
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        ovr_d = 1'b0;
        if (vld_q && out_ack) begin
            vld_d = 1'b0;
        end
        if (in_vld) begin
            if (!vld_q || out_ack) begin
                vld_d = 1'b1;
                dat_d = in_dat;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            ovr_q <= ovr_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: row drive, 2-flop column sync, press/release debounce, binary key events.
// Latency: DEBOUNCE+1 cycles from stable synced column to KEY_VALID; KEYPAD_AUTOREPEAT_EN adds held-key repeats.
// Backpressure: one pending event; a new event while unacked is dropped and flagged on OVERRUN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS       = KP_ROWS,
    parameter int COLS       = KP_COLS,
    parameter int SCAN_DIV   = KP_SCAN_DIV,
    parameter int DEBOUNCE   = KP_DEBOUNCE,
    parameter int REPEAT_DLY = KP_REPEAT_DLY,
    parameter int REPEAT_PER = KP_REPEAT_PER
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           EnableKeyb,
    input  logic [COLS-1:0]                COL_IN,
    output logic [ROWS-1:0]                ROW_DRV,
    output logic [kp_kw(ROWS, COLS)-1:0]   KEY_CODE,
    output logic                           KEY_VALID,
    input  logic                           KEY_ACK,
    output logic                           KEY_DOWN,
    output logic                           OVERRUN
);

    localparam int KW = kp_kw(ROWS, COLS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE + 1);

    kp_state_e       state_q, state_d;
    logic [COLS-1:0] csync1_q, csync_q;
    logic [RW-1:0]   row_q, row_d, row_nxt;
    logic [SW-1:0]   slot_q, slot_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [ROWS-1:0] row_drv_q, row_drv_d;
    logic            key_down_q, key_down_d;
    logic            evt_q, evt_d, evt_acc;
    logic            col_hit;
    logic [KW-1:0]   evt_code;

    function automatic logic [CW-1:0] low_col(input logic [COLS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (v[i]) c = CW'(i);
        end
        return c;
    endfunction

    assign row_nxt  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    assign col_hit  = csync_q[col_q];
    assign evt_code = KW'(int'(row_q) * COLS + int'(col_q));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        slot_d     = slot_q;
        col_d      = col_q;
        deb_d      = deb_q;
        key_down_d = key_down_q;
        evt_acc    = 1'b0;
        if (!EnableKeyb) begin
            // Disabling mid-key abandons it and restarts the scan from row 0.
            if (state_q != ST_SCAN) begin
                state_d    = ST_SCAN;
                row_d      = '0;
                slot_d     = '0;
                deb_d      = '0;
                key_down_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (slot_q == SW'(SCAN_DIV - 1)) begin
                        slot_d = '0;
                        if (|csync_q) begin
                            col_d   = low_col(csync_q);
                            deb_d   = DW'(1);
                            state_d = ST_PRESS_DB;
                        end else begin
                            row_d = row_nxt;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                ST_PRESS_DB: begin
                    if (!col_hit) begin
                        state_d = ST_SCAN;
                        row_d   = row_nxt;
                        deb_d   = '0;
                    end else if (int'(deb_q) + 1 >= DEBOUNCE) begin
                        state_d    = ST_HELD;
                        key_down_d = 1'b1;
                        evt_acc    = 1'b1;
                        deb_d      = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!col_hit) begin
                        state_d = ST_REL_DB;
                        deb_d   = DW'(1);
                    end
                end
                ST_REL_DB: begin
                    if (col_hit) begin
                        state_d = ST_HELD;
                        deb_d   = '0;
                    end else if (int'(deb_q) + 1 >= DEBOUNCE) begin
                        state_d    = ST_SCAN;
                        key_down_d = 1'b0;
                        row_d      = row_nxt;
                        deb_d      = '0;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        row_drv_d = EnableKeyb ? (ROWS'(1) << row_d) : '0;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int PW = $clog2(REPEAT_DLY + 1);

    logic [PW-1:0] rep_q, rep_d;
    logic          rep_fire;

    // rep_q holds cycles since the press was accepted; after each repeat it is
    // rewound so the next one lands REPEAT_PER cycles later.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (EnableKeyb && state_q == ST_HELD && state_d == ST_HELD) begin
            if (int'(rep_q) >= REPEAT_DLY) begin
                rep_fire = 1'b1;
                rep_d    = PW'(REPEAT_DLY - REPEAT_PER + 1);
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end else if (state_q == ST_PRESS_DB && state_d == ST_HELD) begin
            rep_d = PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) rep_q <= '0;
        else        rep_q <= rep_d;
    end

    assign evt_d = evt_acc | rep_fire;
`else
    assign evt_d = evt_acc;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_SCAN;
            csync1_q   <= '0;
            csync_q    <= '0;
            row_q      <= '0;
            slot_q     <= '0;
            col_q      <= '0;
            deb_q      <= '0;
            row_drv_q  <= '0;
            key_down_q <= 1'b0;
            evt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            csync1_q   <= COL_IN;
            csync_q    <= csync1_q;
            row_q      <= row_d;
            slot_q     <= slot_d;
            col_q      <= col_d;
            deb_q      <= deb_d;
            row_drv_q  <= row_drv_d;
            key_down_q <= key_down_d;
            evt_q      <= evt_d;
        end
    end

    keypad_evt_reg #(.W(KW)) u_evt (
        .core_clk (CLK),
        .rst_n    (RESET),
        .in_vld   (evt_q),
        .in_dat   (evt_code),
        .out_vld  (KEY_VALID),
        .out_dat  (KEY_CODE),
        .out_ack  (KEY_ACK),
        .overrun  (OVERRUN)
    );

    assign ROW_DRV  = row_drv_q;
    assign KEY_DOWN = key_down_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a matrix keypad model drives COL_IN from ROW_DRV and the pressed-key set.
// Expected codes come from row*COLS + lowest pressed column; event timing from the repeat rules.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  col_in;
    logic [3:0]  row_drv;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_down;
    logic        overrun;

    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_col;

    int vectors     = 0;
    int miscompares = 0;
    int ovr_cnt     = 0;

    keypad_scan_ctrl dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .EnableKeyb (en),
        .COL_IN     (col_in),
        .ROW_DRV    (row_drv),
        .KEY_CODE   (key_code),
        .KEY_VALID  (key_valid),
        .KEY_ACK    (key_ack),
        .KEY_DOWN   (key_down),
        .OVERRUN    (overrun)
    );

    always #5 clk = ~clk;

    // Passive matrix: a driven row shows its pressed keys on the columns.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_drv[r]) col_in = col_in | pressed[r*4 +: 4];
        end
        if (force_en) col_in = force_col;
    end

    task automatic tick();
        @(negedge clk);
        if (overrun === 1'b1) ovr_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && key_valid !== 1'b1; i++) tick();
        check(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_down(input string tag, input logic val, input int budget);
        for (int i = 0; i < budget && key_down !== val; i++) tick();
        check(tag, 32'(key_down), 32'(val));
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    function automatic int model_code(input int r, input logic [3:0] m);
        int code;
        code = -1;
        for (int c = 3; c >= 0; c--) begin
            if (m[c]) code = r * 4 + c;
        end
        return code;
    endfunction

    initial begin
        int          base_ovr;
        int          vcnt;
        int          n_ev;
        int          ev_t[8];
        int          exp_t[4];
        int          exp_n;
        int          r;
        logic [3:0]  m;
        logic [3:0]  prev;

        rst_n     = 1'b0;
        en        = 1'b1;
        key_ack   = 1'b0;
        pressed   = '0;
        force_en  = 1'b0;
        force_col = '0;
        exp_t     = '{0, 64, 80, 96};
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_row_drv", 32'(row_drv), 32'd0);
            check("rst_valid", 32'(key_valid), 32'd0);
            check("rst_down", 32'(key_down), 32'd0);
            check("rst_ovr", 32'(overrun), 32'd0);
            check("rst_code", 32'(key_code), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("scan_row0", 32'(row_drv), 32'h1);
        repeat (3) tick();
        check("scan_row1", 32'(row_drv), 32'h2);

        // Key 9 pressed and held, no ack
        pressed[9] = 1'b1;
        wait_valid("k9_valid", 100);
        check("k9_code", 32'(key_code), 32'd9);
        check("k9_down", 32'(key_down), 32'd1);
        check("k9_row_held", 32'(row_drv), 32'h4);

        // Release without ack, then press key 5 into the full slot
        pressed[9] = 1'b0;
        wait_down("k9_release", 1'b0, 60);
        check("k9_still_valid", 32'(key_valid), 32'd1);
        base_ovr = ovr_cnt;
        pressed[5] = 1'b1;
        wait_down("k5_down", 1'b1, 100);
        repeat (5) tick();
        check("k5_overrun_once", 32'(ovr_cnt - base_ovr), 32'd1);
        check("k5_code_kept", 32'(key_code), 32'd9);
        check("k5_valid_kept", 32'(key_valid), 32'd1);
        ack_pulse();
        check("ack_clears", 32'(key_valid), 32'd0);
        pressed[5] = 1'b0;
        wait_down("k5_release", 1'b0, 60);

        // Five-cycle bounce while row 1 is driven
        prev = row_drv;
        for (int i = 0; i < 60 && !(row_drv == 4'h2 && prev != 4'h2); i++) begin
            prev = row_drv;
            tick();
        end
        check("bounce_at_row1", 32'(row_drv), 32'h2);
        vcnt      = 0;
        force_col = 4'b0010;
        force_en  = 1'b1;
        repeat (5) begin
            tick();
            if (key_valid === 1'b1 || key_down === 1'b1) vcnt++;
        end
        force_en = 1'b0;
        for (int i = 0; i < 40 && row_drv == 4'h2; i++) begin
            tick();
            if (key_valid === 1'b1 || key_down === 1'b1) vcnt++;
        end
        check("bounce_next_row", 32'(row_drv), 32'h4);
        repeat (30) begin
            tick();
            if (key_valid === 1'b1 || key_down === 1'b1) vcnt++;
        end
        check("bounce_no_event", 32'(vcnt), 32'd0);

        // Two columns on row 0: lowest wins
        pressed[2] = 1'b1;
        pressed[3] = 1'b1;
        wait_valid("multi_valid", 100);
        check("multi_code", 32'(key_code), 32'd2);
        ack_pulse();
        check("multi_ack", 32'(key_valid), 32'd0);
        pressed = '0;
        wait_down("multi_release", 1'b0, 60);

        // Held key 0 with every event acked
        base_ovr = ovr_cnt;
        pressed[0] = 1'b1;
        wait_valid("rep_first", 100);
        check("rep_code0", 32'(key_code), 32'd0);
        n_ev    = 1;
        ev_t[0] = 0;
        key_ack = 1'b1;
        for (int t = 1; t < 100; t++) begin
            tick();
            key_ack = 1'b0;
            if (key_valid === 1'b1) begin
                if (n_ev < 8) ev_t[n_ev] = t;
                n_ev++;
                check("rep_code", 32'(key_code), 32'd0);
                key_ack = 1'b1;
            end
        end
        tick();
        key_ack = 1'b0;
        check("rep_count", 32'(n_ev), 32'(exp_n));
        for (int i = 1; i < exp_n && i < n_ev; i++) begin
            check("rep_time", 32'(ev_t[i]), 32'(exp_t[i]));
        end
        check("rep_no_overrun", 32'(ovr_cnt - base_ovr), 32'd0);
        pressed = '0;
        wait_down("rep_release", 1'b0, 60);
        if (key_valid === 1'b1) ack_pulse();

        // Disable while held: pending event survives, scan restarts at row 0
        pressed[6] = 1'b1;
        wait_valid("en_valid", 100);
        en = 1'b0;
        tick();
        check("en_down_off", 32'(key_down), 32'd0);
        check("en_row_off", 32'(row_drv), 32'd0);
        repeat (4) tick();
        check("en_pending_kept", 32'(key_valid), 32'd1);
        check("en_code_kept", 32'(key_code), 32'd6);
        pressed = '0;
        ack_pulse();
        check("en_ack", 32'(key_valid), 32'd0);
        en = 1'b1;
        tick();
        check("en_row0", 32'(row_drv), 32'h1);

        // Reset mid-operation drops the pending event
        pressed[13] = 1'b1;
        wait_valid("mid_valid", 100);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_down", 32'(key_down), 32'd0);
        check("mid_rst_row", 32'(row_drv), 32'd0);
        pressed = '0;
        rst_n   = 1'b1;
        tick();

        // Random single-row presses against the matrix model
        for (int it = 0; it < 8; it++) begin
            r = int'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
            pressed = '0;
            pressed[r*4 +: 4] = m;
            wait_valid("rnd_valid", 100);
            check("rnd_code", 32'(key_code), 32'(model_code(r, m)));
            check("rnd_down", 32'(key_down), 32'd1);
            check("rnd_row", 32'(row_drv), 32'(4'b0001 << r));
            repeat ($urandom_range(0, 5)) tick();
            ack_pulse();
            check("rnd_ack", 32'(key_valid), 32'd0);
            pressed = '0;
            wait_down("rnd_release", 1'b0, 60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
